// File: rtl/vending_fsm_multi.sv
// Moore vending controller: accumulates coin credit, vends product A or B and keeps the
// remainder, and returns change on request or after an inactivity timeout.
module vending_fsm_multi #(
    parameter int unsigned CREDIT_W   = 4,
    parameter int unsigned MAX_CREDIT = 9,
    parameter int unsigned PRICE_A    = 1,
    parameter int unsigned PRICE_B    = 3,
    parameter int unsigned VEND_CYC   = 2,
    parameter int unsigned TIMEOUT    = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_coin,
    input  logic                i_sel_a,
    input  logic                i_sel_b,
    input  logic                i_refund,
    output logic                o_led_a,
    output logic                o_led_b,
    output logic                o_vend_a,
    output logic                o_vend_b,
    output logic                o_change,
    output logic                o_coin_reject,
    output logic [CREDIT_W-1:0] o_credit
);

    localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned VC_W   = (VEND_CYC > 1) ? $clog2(VEND_CYC) : 1;

    localparam logic [CREDIT_W-1:0] PRICE_A_C = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] PRICE_B_C = CREDIT_W'(PRICE_B);
    localparam logic [CREDIT_W-1:0] MAX_C     = CREDIT_W'(MAX_CREDIT);
    localparam logic [IDLE_W-1:0]   IDLE_LAST = (TIMEOUT == 0) ? '0 : IDLE_W'(TIMEOUT - 1);
    localparam logic [VC_W-1:0]     VEND_LAST = VC_W'(VEND_CYC - 1);

    if (!(PRICE_A >= 1 && PRICE_B >= 1 && PRICE_A <= MAX_CREDIT && PRICE_B <= MAX_CREDIT &&
          MAX_CREDIT < (1 << CREDIT_W) && VEND_CYC >= 1)) begin : g_param_err
        $error("vending_fsm_multi: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    state_t                state;
    logic [CREDIT_W-1:0]   credit;
    logic [IDLE_W-1:0]     idle_cnt;
    logic [VC_W-1:0]       vend_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            credit        <= '0;
            idle_cnt      <= '0;
            vend_cnt      <= '0;
            o_vend_a      <= 1'b0;
            o_vend_b      <= 1'b0;
            o_change      <= 1'b0;
            o_coin_reject <= 1'b0;
        end else begin
            o_coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_coin) begin
                        credit   <= CREDIT_W'(1);
                        idle_cnt <= '0;
                        state    <= CREDIT;
                    end
                end
                // One event per cycle; a coin loses to any accepted refund or select.
                CREDIT: begin
                    if (i_refund) begin
                        o_coin_reject <= i_coin;
                        o_change      <= 1'b1;
                        credit        <= credit - CREDIT_W'(1);
                        state         <= CHANGE;
                    end else if (i_sel_a && credit >= PRICE_A_C) begin
                        o_coin_reject <= i_coin;
                        o_vend_a      <= 1'b1;
                        credit        <= credit - PRICE_A_C;
                        vend_cnt      <= VEND_LAST;
                        state         <= VEND;
                    end else if (i_sel_b && credit >= PRICE_B_C) begin
                        o_coin_reject <= i_coin;
                        o_vend_b      <= 1'b1;
                        credit        <= credit - PRICE_B_C;
                        vend_cnt      <= VEND_LAST;
                        state         <= VEND;
                    end else if (i_coin && credit < MAX_C) begin
                        credit   <= credit + CREDIT_W'(1);
                        idle_cnt <= '0;
                    end else begin
                        o_coin_reject <= i_coin;
                        if (TIMEOUT != 0 && idle_cnt == IDLE_LAST) begin
                            o_change <= 1'b1;
                            credit   <= credit - CREDIT_W'(1);
                            state    <= CHANGE;
                        end else begin
                            idle_cnt <= idle_cnt + IDLE_W'(1);
                        end
                    end
                end
                VEND: begin
                    o_coin_reject <= i_coin;
                    if (vend_cnt == '0) begin
                        o_vend_a <= 1'b0;
                        o_vend_b <= 1'b0;
                        idle_cnt <= '0;
                        state    <= (credit == '0) ? IDLE : CREDIT;
                    end else begin
                        vend_cnt <= vend_cnt - VC_W'(1);
                    end
                end
                // First unit was paid on entry; alternate low/high until credit is exhausted.
                CHANGE: begin
                    o_coin_reject <= i_coin;
                    if (o_change) begin
                        o_change <= 1'b0;
                        if (credit == '0) begin
                            state <= IDLE;
                        end
                    end else begin
                        o_change <= 1'b1;
                        credit   <= credit - CREDIT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_credit = credit;
    assign o_led_a  = (state == CREDIT) && (credit >= PRICE_A_C);
    assign o_led_b  = (state == CREDIT) && (credit >= PRICE_B_C);

endmodule
